// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   DefaultWidth : default operand width in bits
//   state_e      : control FSM states (idle, running, result valid)
package serial_adder_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_full_add.sv
// One-bit combinational full adder used as the serial adder's datapath cell.
//   a, b  : operand bits
//   c_in  : carry in
//   sum   : a ^ b ^ c_in
//   c_out : carry out
module full_add (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic p;

    always_comb begin
        p     = a ^ b;
        sum   = p ^ c_in;
        c_out = (a & b) | (c_in & p);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus a carry-in, one bit per
// clock, LSB first, and presents a registered result with a one-cycle done.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request an add; accepted when idle or in the done cycle
//   a, b     : addends, sampled with start
//   c_in     : carry-in, sampled with start
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when sum/c_out/overflow take a new value
//   sum      : a + b + c_in mod 2^WIDTH, held between done pulses
//   c_out    : carry out of the MSB
//   overflow : two's-complement overflow (carry into MSB ^ carry out of MSB)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;       // addend A, doubles as the result shift register
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [CntW-1:0]   cnt_q;

    logic              fa_sum;
    logic              fa_cout;

    full_add u_full_add (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= c_in;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    // As A's bits are consumed from the bottom, sum bits enter at the top.
                    a_q     <= {fa_sum, a_q[WIDTH-1:1]};
                    b_q     <= b_q >> 1;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        state_q  <= StDone;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= {fa_sum, a_q[WIDTH-1:1]};
                        c_out    <= fa_cout;
                        // carry_q is the carry into the MSB on this last step.
                        overflow <= carry_q ^ fa_cout;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int total;
    int bad;

    serial_adder #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for exactly one rising edge; returns 1ns after it.
    task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a     = av;
        b     = bv;
        c_in  = cv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        c_in  = ~cv;
    endtask

    // Count edges until done is seen (bounded) and samples with busy high.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) bcnt++;
        end
    endtask

    task automatic run_add(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, input logic [W-1:0] es, input logic ec,
                           input logic eo);
        int lat;
        int bc;
        do_start(av, bv, cv);
        wait_done(lat, bc);
        chk({tag, ".latency"}, 32'(lat), 32'd8);
        chk({tag, ".busy_cycles"}, 32'(bc), 32'd8);
        chk({tag, ".sum"}, 32'(sum), 32'(es));
        chk({tag, ".c_out"}, 32'(c_out), 32'(ec));
        chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".sum_hold"}, 32'(sum), 32'(es));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int bc;
        int extra;
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.c_out", 32'(c_out), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_add("basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_add("cin",   8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        run_add("wrap",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_add("ovf1",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_add("ovf2",  8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

        // Ignored start on the third RUN cycle; previous result must hold meanwhile.
        do_start(8'h10, 8'h20, 1'b0);
        chk("ign.busy", 32'(busy), 32'd1);
        chk("ign.sum_hold_run", 32'(sum), 32'h01);
        chk("ign.cout_hold_run", 32'(c_out), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        do_start(8'hFF, 8'hFF, 1'b1);
        wait_done(lat, bc);
        chk("ign.latency", 32'(lat), 32'd5);
        chk("ign.sum", 32'(sum), 32'h30);
        chk("ign.c_out", 32'(c_out), 32'd0);
        chk("ign.overflow", 32'(overflow), 32'd0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        chk("ign.single_done", 32'(extra), 32'd0);

        // Reset during the fourth RUN cycle.
        do_start(8'h55, 8'h11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.sum", 32'(sum), 32'd0);
        chk("midrst.c_out", 32'(c_out), 32'd0);
        chk("midrst.overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        chk("midrst.no_done", 32'(extra), 32'd0);

        // Back-to-back: second start issued during the DONE cycle.
        do_start(8'h01, 8'h02, 1'b0);
        wait_done(lat, bc);
        chk("b2b1.latency", 32'(lat), 32'd8);
        chk("b2b1.sum", 32'(sum), 32'h03);
        do_start(8'h03, 8'h04, 1'b0);
        chk("b2b.done_drop", 32'(done), 32'd0);
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.sum_hold", 32'(sum), 32'h03);
        wait_done(lat, bc);
        chk("b2b2.latency", 32'(lat), 32'd8);
        chk("b2b2.busy_cycles", 32'(bc), 32'd8);
        chk("b2b2.sum", 32'(sum), 32'h07);
        chk("b2b2.c_out", 32'(c_out), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b2.done_pulse", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
